// File: rtl/i2c_handler_pkg.sv
// Shared opcodes and FSM state encoding for the I2C register-bank command handler.
package i2c_handler_pkg;
  localparam logic [7:0] CMD_SET_ADDR = 8'h14;
  localparam logic [7:0] CMD_WRITE    = 8'h15;
  localparam logic [7:0] CMD_READ     = 8'h16;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    EXEC_ADDR,
    COMMIT,
    UPLOAD,
    FINISH
  } state_t;
endpackage

// File: rtl/i2c_handler_regfile.sv
// Byte register bank with a priority handler write port, an I2C-core write port,
// a combinational core read port and a flattened view of all registers.
module i2c_handler_regfile #(
  parameter int NUM_REGS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hw_en,
  input  logic [$clog2(NUM_REGS)-1:0] hw_addr,
  input  logic [7:0]            hw_data,
  input  logic                  core_wr_en,
  input  logic [7:0]            core_addr,
  input  logic [7:0]            core_wdata,
  output logic [7:0]            core_rdata,
  output logic [8*NUM_REGS-1:0] reg_flat
);
  localparam int         REG_AW = $clog2(NUM_REGS);
  localparam logic [8:0] NREGS9 = 9'(NUM_REGS);

  logic [NUM_REGS-1:0][7:0] regs;

  // Handler port wins a same-register collision; core addresses past the bank never match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (hw_en && hw_addr == REG_AW'(i))
          regs[i] <= hw_data;
        else if (core_wr_en && core_addr == 8'(i))
          regs[i] <= core_wdata;
      end
    end
  end

  assign core_rdata = ({1'b0, core_addr} < NREGS9) ? regs[core_addr[REG_AW-1:0]] : 8'h00;
  assign reg_flat   = regs;
endmodule

// File: rtl/i2c_slave_regbank_handler.sv
// CDC-command handler for the I2C slave register bank: set-address, bulk write and,
// when I2C_HANDLER_UPLOAD_EN is defined, snapshot read-back over the upload bus.
module i2c_slave_regbank_handler
  import i2c_handler_pkg::*;
#(
  parameter int         NUM_REGS           = 4,
  parameter logic [6:0] DEFAULT_SLAVE_ADDR = 7'h24,
  parameter logic [7:0] UPLOAD_SOURCE      = 8'h07
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            cmd_type,
  input  logic [15:0]           cmd_length,
  input  logic [7:0]            cmd_data,
  input  logic [15:0]           cmd_data_index,
  input  logic                  cmd_start,
  input  logic                  cmd_data_valid,
  input  logic                  cmd_done,
  output logic                  cmd_ready,
  output logic                  upload_active,
  output logic                  upload_req,
  output logic [7:0]            upload_data,
  output logic [7:0]            upload_source,
  output logic                  upload_valid,
  input  logic                  upload_ready,
  output logic [6:0]            slave_addr,
  input  logic [7:0]            core_addr,
  input  logic [7:0]            core_wdata,
  input  logic                  core_wr_en,
  output logic [7:0]            core_rdata,
  output logic [8*NUM_REGS-1:0] reg_flat
);
  localparam int          REG_AW  = $clog2(NUM_REGS);
  localparam int          CW      = REG_AW + 1;
  localparam logic [8:0]  NREGS9  = 9'(NUM_REGS);
  localparam logic [15:0] NREGS16 = 16'(NUM_REGS);

  state_t                   state, state_nxt;
  logic [7:0]               start_reg, start_eff;
  logic [NUM_REGS-1:0][7:0] wbuf;
  logic [REG_AW-1:0]        wb_idx, ptr;
  logic [CW-1:0]            wlen, widx;
  logic [15:0]              len_m1, wlen_calc;
  logic                     start_ok, cap_data;

  function automatic logic [REG_AW-1:0] inc_wrap(input logic [REG_AW-1:0] a);
    return (a == REG_AW'(NUM_REGS - 1)) ? '0 : a + REG_AW'(1);
  endfunction

  assign cap_data  = (state == CAPTURE) && cmd_data_valid;
  // A payload byte arriving together with cmd_done still takes part in the decode.
  assign start_eff = (cap_data && cmd_data_index == 16'd0) ? cmd_data : start_reg;
  assign start_ok  = {1'b0, start_eff} < NREGS9;
  assign len_m1    = cmd_length - 16'd1;
  assign wlen_calc = (len_m1 > NREGS16) ? NREGS16 : len_m1;
  assign wb_idx    = REG_AW'(cmd_data_index - 16'd1);
  assign cmd_ready = (state == IDLE);
  assign upload_source = UPLOAD_SOURCE;

  i2c_handler_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .hw_en      (state == COMMIT),
    .hw_addr    (ptr),
    .hw_data    (wbuf[widx[REG_AW-1:0]]),
    .core_wr_en (core_wr_en),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .reg_flat   (reg_flat)
  );

`ifdef I2C_HANDLER_UPLOAD_EN
  logic [NUM_REGS-1:0][7:0] snap;
  logic [REG_AW-1:0]        rd;
  logic [7:0]               count, count_eff, n_left;

  assign count_eff = (cap_data && cmd_data_index == 16'd1) ? cmd_data : count;

  // Snapshot decouples the streamed bytes from core writes during the upload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap   <= '0;
      rd     <= '0;
      n_left <= '0;
      count  <= '0;
    end else begin
      if (cap_data && cmd_data_index == 16'd1) count <= cmd_data;
      if (state == CAPTURE && state_nxt == UPLOAD) begin
        snap   <= reg_flat;
        rd     <= start_eff[REG_AW-1:0];
        n_left <= count_eff;
      end else if (upload_valid) begin
        rd     <= inc_wrap(rd);
        n_left <= n_left - 8'd1;
      end
    end
  end

  assign upload_active = (state == UPLOAD);
  assign upload_req    = (state == UPLOAD);
  assign upload_valid  = upload_req & upload_ready;
  assign upload_data   = upload_req ? snap[rd] : 8'h00;
`else
  logic unused_upload_ready;
  assign unused_upload_ready = upload_ready;
  assign upload_active = 1'b0;
  assign upload_req    = 1'b0;
  assign upload_valid  = 1'b0;
  assign upload_data   = 8'h00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_start) state_nxt = CAPTURE;
      CAPTURE: if (cmd_done) begin
        state_nxt = FINISH;
        if (cmd_length != 16'd0) begin
          case (cmd_type)
            CMD_SET_ADDR: state_nxt = EXEC_ADDR;
            CMD_WRITE:    if (start_ok && wlen_calc != 16'd0) state_nxt = COMMIT;
`ifdef I2C_HANDLER_UPLOAD_EN
            CMD_READ:     if (start_ok && count_eff != 8'd0) state_nxt = UPLOAD;
`endif
            default:      state_nxt = FINISH;
          endcase
        end
      end
      EXEC_ADDR: state_nxt = FINISH;
      COMMIT:    if (widx + CW'(1) == wlen) state_nxt = FINISH;
`ifdef I2C_HANDLER_UPLOAD_EN
      UPLOAD:    if (upload_valid && n_left == 8'd1) state_nxt = FINISH;
`endif
      FINISH:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_reg  <= '0;
      wbuf       <= '0;
      wlen       <= '0;
      widx       <= '0;
      ptr        <= '0;
      slave_addr <= DEFAULT_SLAVE_ADDR;
    end else begin
      if (cap_data) begin
        if (cmd_data_index == 16'd0) start_reg <= cmd_data;
        if (cmd_data_index != 16'd0 && cmd_data_index <= NREGS16) wbuf[wb_idx] <= cmd_data;
      end
      if (state == CAPTURE && cmd_done) begin
        wlen <= CW'(wlen_calc);
        widx <= '0;
        ptr  <= start_eff[REG_AW-1:0];
      end
      if (state == EXEC_ADDR) slave_addr <= start_reg[6:0];
      if (state == COMMIT) begin
        widx <= widx + CW'(1);
        ptr  <= inc_wrap(ptr);
      end
    end
  end
endmodule
